// File: rtl/verdict_collector.sv
// verdict_collector: timestamps active monitor outputs, queues them as
// records and streams each record out as 64-bit words.
module verdict_collector #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic signed [63:0]     output_0,
    input  logic                   output_0_aktv,
    input  logic signed [63:0]     output_1,
    input  logic                   output_1_aktv,
    output logic [63:0]            rec_data,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic                   rec_last,
    output logic                   overflow,
    output logic [15:0]            drop_count,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, HDR, V0, V1} state_t;

    state_t state;

    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] mem_ts [DEPTH];
    logic [1:0]      mem_mask [DEPTH];
    logic [63:0]     mem_v0 [DEPTH];
    logic [63:0]     mem_v1 [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] nx_ptr;
    logic [AW-1:0] hd_ptr;

    logic [1:0]  mask;
    logic [1:0]  cur_mask;
    logic [63:0] hd_word;
    logic        push_req;
    logic        full;
    logic        push;
    logic        drop;
    logic        hs;
    logic        pop;
    logic        more;

    assign mask     = {output_1_aktv, output_0_aktv};
    assign full     = fifo_level == LVL_FULL;
    assign push_req = en && (mask != 2'b00);
    assign push     = push_req && !full;
    assign drop     = push_req && full;
    assign hs       = rec_valid && rec_ready && en;
    assign pop      = hs && rec_last;
    assign more     = fifo_level > LVL_ONE;
    assign nx_ptr   = rd_ptr + AW'(1);
    assign cur_mask = mem_mask[rd_ptr];

    // The header loaded next belongs to the head record when idle, or to
    // the record behind it when chaining straight out of a finished one.
    assign hd_ptr  = (state == IDLE) ? rd_ptr : nx_ptr;
    assign hd_word = {48'(mem_ts[hd_ptr]), 14'd0, mem_mask[hd_ptr]};

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_ts[wr_ptr]   <= ts;
            mem_mask[wr_ptr] <= mask;
            mem_v0[wr_ptr]   <= output_0;
            mem_v1[wr_ptr]   <= output_1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ts         <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            rec_data   <= '0;
            rec_valid  <= 1'b0;
            rec_last   <= 1'b0;
        end else begin
            if (en)
                ts <= ts + TS_W'(1);
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= nx_ptr;
            if (push && !pop)
                fifo_level <= fifo_level + LVL_ONE;
            else if (!push && pop)
                fifo_level <= fifo_level - LVL_ONE;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF)
                    drop_count <= drop_count + 16'd1;
            end

            unique case (state)
                IDLE: begin
                    if (en && fifo_level != '0) begin
                        state     <= HDR;
                        rec_valid <= 1'b1;
                        rec_data  <= hd_word;
                        rec_last  <= 1'b0;
                    end
                end
                HDR: begin
                    if (hs) begin
                        if (cur_mask[0]) begin
                            state    <= V0;
                            rec_data <= mem_v0[rd_ptr];
                            rec_last <= !cur_mask[1];
                        end else begin
                            state    <= V1;
                            rec_data <= mem_v1[rd_ptr];
                            rec_last <= 1'b1;
                        end
                    end
                end
                V0: begin
                    if (hs && !rec_last) begin
                        state    <= V1;
                        rec_data <= mem_v1[rd_ptr];
                        rec_last <= 1'b1;
                    end
                end
                V1: begin
                end
            endcase

            if (pop) begin
                rec_last <= 1'b0;
                if (more) begin
                    state    <= HDR;
                    rec_data <= hd_word;
                end else begin
                    state     <= IDLE;
                    rec_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/verdict_collector.md
# verdict_collector

Sink for the generated monitor's output interface: samples every output value and its `_aktv` flag each clock, stamps active cycles with a free-running cycle counter, buffers records in a small FIFO and streams them out as 64-bit words over a valid/ready channel. It sits between the `topEntity` monitor and a host or log port, replacing `$display` tracing in synthesized builds.

## Interface
- `DEPTH`, 4: record FIFO depth, power of two, ≥2.
- `TS_W`, 48: timestamp width, ≤48.

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: global enable, same meaning as the monitor's `en`.
- `output_0` in 64 signed: monitor output 0 value.
- `output_0_aktv` in 1: output 0 produced a value this cycle.
- `output_1` in 64 signed: monitor output 1 value.
- `output_1_aktv` in 1: output 1 produced a value this cycle.
- `rec_data` out 64: stream word.
- `rec_valid` out 1: `rec_data` holds a valid word.
- `rec_ready` in 1: consumer accepts the word.
- `rec_last` out 1: current word is the last of its record.
- `overflow` out 1: sticky; at least one record was dropped since reset.
- `drop_count` out 16: dropped-record count, saturates at 65535.
- `fifo_level` out log2(DEPTH)+1: records currently buffered.

## Operation
- Timestamp counter `ts`: TS_W bits, 0 at reset, +1 on each edge with `en=1`, wraps modulo 2^TS_W.
- Capture: on an edge with `en=1` and mask = {`output_1_aktv`,`output_0_aktv`} ≠ 0, one record {ts (pre-increment), mask, output_0, output_1} is pushed.
- Full rule: the push is dropped if the FIFO is full, evaluated before any same-edge pop. A same-edge pop does not make room. On a drop, `overflow` is set and `drop_count` increments, saturating.
- Record format, emitted in order:
  - Header word: [63:16] = ts zero-extended, [15:2] = 0, [1:0] = mask.
  - Then `output_0` if mask[0], then `output_1` if mask[1].
  - `rec_last` is high on the final word of each record.
- Serializer FSM:
  - IDLE: if the FIFO is non-empty, go to HDR.
  - HDR: on handshake, go to V0 if mask[0], else V1.
  - V0: on handshake, go to V1 if mask[1], else DONE.
  - V1: on handshake, go to DONE.
  - DONE is not a state. The FIFO pops on the handshake of the last word. The FSM then goes to HDR if further records are buffered, else IDLE.
- Handshake: a word transfers on an edge with `rec_valid && rec_ready && en`. While `rec_valid=1` and the word has not transferred, `rec_data` and `rec_last` stay stable.
- `en=0`: no capture, `ts` frozen, FSM frozen, no transfer. Outputs hold their values and `rec_ready` is ignored.
- Simultaneous push and pop on a non-full FIFO are both performed, and `fifo_level` is unchanged.

## Timing
- Reset values: `rec_valid=0`, `rec_last=0`, `rec_data=0`, `overflow=0`, `drop_count=0`, `fifo_level=0`, FSM in IDLE, `ts=0`.
- Reset takes effect at the edge where `rst=1` and overrides `en`.
- Mid-record reset discards all buffered and partially sent records. No `rec_last` follows.
- All outputs are registered.
- Latency: a record captured at edge t is in `fifo_level` after edge t. With the FSM idle, `rec_valid` is high with the header after edge t+1.
- With `rec_ready` held high, a record of n words occupies exactly n consecutive cycles.
- Back-to-back records run with no idle cycle between them.
- Peak throughput is 1 word per cycle. The sustained capture rate exceeds drain rate when every cycle has an active output; the FIFO absorbs bursts of up to DEPTH records.

## Test plan
- Single event: `output_0_aktv=1`, `output_0=1` captured at ts=500, `rec_ready=1` → header 0x1F4_0001 (ts 500 in [63:16], mask 01), then word 1 with `rec_last=1`. `rec_valid` rises one cycle after capture.
- Both active: ts=10, values 7 and −3 → header 0xA_0003, then 7, then 0xFFFF_FFFF_FFFF_FFFD with `rec_last=1`. Three consecutive words.
- Backpressure: `rec_ready=0` for 5 cycles mid-record → `rec_data` and `rec_last` are unchanged for all 5 cycles, and no word is lost or duplicated after `rec_ready` returns.
- Overflow: `rec_ready=0`, DEPTH=4, six consecutive active cycles → `fifo_level=4`, `drop_count=2`, `overflow=1`. The drained records carry the first four timestamps in order.
- Full with same-edge pop: FIFO full and last word transferring on the same edge as a new capture → the capture is dropped, `drop_count` increments, and `fifo_level` goes 4→3.
- Reset and enable: `rst` asserted mid-record → next cycle all outputs are at reset values, and a new event at ts=0 is emitted correctly. With `en=0` for 3 cycles, `ts` does not advance, active flags are not captured, and the in-flight word is held.
